// File: rtl/led_mode_master.sv
// led_mode_master: initiator side of the valid/ready/2-bit LED-mode link.
// Advances the mode code on a prescaler tick or a manual step request.
// Each advance runs one valid/ready handshake with the responder.
// Optional macro LED_MODE_MASTER_REVERSE_EN adds a `reverse` input that
// makes an advance decrement the mode instead of incrementing it.
module led_mode_master #(
  parameter int         TICK_DIV       = 50000000,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [1:0] INIT_MODE      = 2'd0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       step_req,
  input  logic       err_clr,
  input  logic       ready,
`ifdef LED_MODE_MASTER_REVERSE_EN
  input  logic       reverse,
`endif
  output logic       valid,
  output logic [1:0] data,
  output logic       busy,
  output logic [1:0] mode,
  output logic       timeout_err
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic          pending;
  logic          tick;
  logic          adv;
  logic          abort;
  logic          rev;

`ifdef LED_MODE_MASTER_REVERSE_EN
  assign rev = reverse;
`else
  assign rev = 1'b0;
`endif

  assign tick  = enable && (pcnt == TICK_LAST);
  assign adv   = tick || step_req;
  // Abort only when the last allowed wait cycle also passes without ready.
  assign abort = (state == REQ) && !ready && (tcnt == TO_LAST);

  // Free-running prescaler, held at zero while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        pcnt <= '0;
    else if (!enable) pcnt <= '0;
    else if (tick)    pcnt <= '0;
    else              pcnt <= pcnt + 1'b1;
  end

  // Sticky timeout flag; a same-cycle abort beats the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        timeout_err <= 1'b0;
    else if (abort)   timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

  // Handshake FSM with registered valid/data/busy/mode and pending advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      valid   <= 1'b0;
      busy    <= 1'b0;
      data    <= INIT_MODE;
      mode    <= INIT_MODE;
      tcnt    <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Any pending advance is consumed here; a stray ready is ignored.
          pending <= 1'b0;
          if (adv || pending) begin
            state <= REQ;
            busy  <= 1'b1;
            valid <= 1'b1;
            data  <= rev ? (mode - 2'd1) : (mode + 2'd1);
            tcnt  <= '0;
          end
        end
        REQ: begin
          if (adv) pending <= 1'b1;
          if (ready) begin
            mode  <= data;
            valid <= 1'b0;
            state <= RELEASE;
          end else if (tcnt == TO_LAST) begin
            // No commit: put the old mode back on the wire.
            valid <= 1'b0;
            data  <= mode;
            state <= RELEASE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RELEASE: begin
          if (adv) pending <= 1'b1;
          // Responder ready lags valid; never re-request while it is high.
          if (!ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_master.sv
// Directed self-checking bench for led_mode_master.
module tb_led_mode_master;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic       step_req;
  logic       err_clr;
  logic       ready;
  logic       valid;
  logic [1:0] data;
  logic       busy;
  logic [1:0] mode;
  logic       timeout_err;
`ifdef LED_MODE_MASTER_REVERSE_EN
  logic       reverse = 1'b0;
`endif

  // Responder model: ready is registered valid, optionally forced high.
  logic rdy_r;
  logic resp_reg;
  logic force_hi;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_r <= 1'b0;
    else       rdy_r <= valid;
  end

  always_comb ready = force_hi | (resp_reg & rdy_r);

  led_mode_master #(.TICK_DIV(4), .TIMEOUT_CYCLES(16), .INIT_MODE(2'd0)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .step_req(step_req),
    .err_clr(err_clr), .ready(ready),
`ifdef LED_MODE_MASTER_REVERSE_EN
    .reverse(reverse),
`endif
    .valid(valid), .data(data), .busy(busy), .mode(mode),
    .timeout_err(timeout_err)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step();
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; step_req = 1'b0; err_clr = 1'b0;
    resp_reg = 1'b1; force_hi = 1'b0;
    cyc(2);
    tests++;
    if ({valid, busy, timeout_err, mode, data} !== 7'b0) begin
      fails++;
      $display("FAIL reset: valid=%b busy=%b err=%b mode=%0d data=%0d, want all 0",
               valid, busy, timeout_err, mode, data);
    end
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_step();
    step();
    tests++;
    if (valid !== 1'b1 || data !== 2'd1 || busy !== 1'b1 || mode !== 2'd0) begin
      fails++;
      $display("FAIL step_req: valid=%b data=%0d busy=%b mode=%0d, want 1 1 1 0",
               valid, data, busy, mode);
    end
    cyc(2);
    tests++;
    if (mode !== 2'd1 || valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL step_commit: mode=%0d valid=%b busy=%b, want 1 0 1", mode, valid, busy);
    end
    cyc(1);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL step_release: busy=%b, want 1", busy);
    end
    cyc(1);
    tests++;
    if (busy !== 1'b0 || data !== 2'd1) begin
      fails++;
      $display("FAIL step_idle: busy=%b data=%0d, want 0 1", busy, data);
    end
  endtask

  task automatic test_wrap();
    for (int i = 2; i <= 4; i++) begin
      logic [1:0] exp;
      exp = 2'(i);
      step();
      tests++;
      if (data !== exp || valid !== 1'b1) begin
        fails++;
        $display("FAIL wrap_data%0d: data=%0d valid=%b, want %0d 1", i, data, valid, exp);
      end
      cyc(4);
      tests++;
      if (mode !== exp || busy !== 1'b0) begin
        fails++;
        $display("FAIL wrap_mode%0d: mode=%0d busy=%b, want %0d 0", i, mode, busy, exp);
      end
    end
  endtask

  task automatic test_ticks();
    int         first_rise;
    int         ncommit;
    int         ccyc [8];
    logic [1:0] cval [8];
    logic       pv;
    logic [1:0] pm;
    first_rise = -1; ncommit = 0;
    pv = valid; pm = mode;
    enable = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cyc(1);
      if (valid && !pv && first_rise < 0) first_rise = c;
      if (mode !== pm && ncommit < 8) begin
        ccyc[ncommit] = c; cval[ncommit] = mode; ncommit++;
      end
      pv = valid; pm = mode;
    end
    enable = 1'b0;
    tests++;
    if (first_rise !== 4) begin
      fails++;
      $display("FAIL tick_first: valid rose at cycle %0d, want 4", first_rise);
    end
    tests++;
    if (ncommit !== 5) begin
      fails++;
      $display("FAIL tick_count: %0d commits, want 5", ncommit);
    end
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ev;
      ev = 2'(k + 1);
      tests++;
      if (k >= ncommit || ccyc[k] !== 6 + 5 * k || cval[k] !== ev) begin
        fails++;
        $display("FAIL tick_seq%0d: cycle=%0d mode=%0d, want cycle %0d mode %0d",
                 k, (k < ncommit) ? ccyc[k] : -1, (k < ncommit) ? cval[k] : 2'd0,
                 6 + 5 * k, ev);
      end
    end
    cyc(15);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL tick_drain: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    resp_reg = 1'b0;
    step();
    cnt = 0;
    while (valid && cnt < 40) begin
      cnt++;
      cyc(1);
    end
    tests++;
    if (cnt !== 16) begin
      fails++;
      $display("FAIL timeout_len: valid high %0d cycles, want 16", cnt);
    end
    tests++;
    if (data !== 2'd0 || mode !== 2'd0 || timeout_err !== 1'b1 || valid !== 1'b0) begin
      fails++;
      $display("FAIL timeout_state: data=%0d mode=%0d err=%b valid=%b, want 0 0 1 0",
               data, mode, timeout_err, valid);
    end
    cyc(2);
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr_first: err=%b, want 0", timeout_err);
    end
    step();
    cyc(15);
    tests++;
    if (valid !== 1'b1 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL err_pre_abort: valid=%b err=%b, want 1 0", valid, timeout_err);
    end
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    tests++;
    if (valid !== 1'b0 || timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL err_set_wins: valid=%b err=%b, want 0 1", valid, timeout_err);
    end
    cyc(2);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr_alone: err=%b, want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    resp_reg = 1'b1;
    step();
    cyc(4);
    resp_reg = 1'b0;
    step();
    cyc(18);
    step();
    cyc(2);
    tests++;
    if (valid !== 1'b1 || data !== 2'd2 || mode !== 2'd1 || timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup: valid=%b data=%0d mode=%0d err=%b, want 1 2 1 1",
               valid, data, mode, timeout_err);
    end
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({valid, busy, timeout_err, mode, data} !== 7'b0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b busy=%b err=%b mode=%0d data=%0d, want all 0",
               valid, busy, timeout_err, mode, data);
    end
    cyc(1);
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_ready_hold();
    int rise;
    int bad;
    resp_reg = 1'b1;
    step();
    cyc(2);
    force_hi = 1'b1;
    tests++;
    if (mode !== 2'd1 || valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_commit: mode=%0d valid=%b, want 1 0", mode, valid);
    end
    step();
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_release: %0d cycles left RELEASE or raised valid, want 0", bad);
    end
    force_hi = 1'b0;
    rise = -1;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      if (valid && rise < 0) rise = k;
    end
    tests++;
    if (rise !== 2) begin
      fails++;
      $display("FAIL hold_pending: valid rose at %0d, want 2", rise);
    end
    cyc(4);
    force_hi = 1'b1;
    cyc(3);
    force_hi = 1'b0;
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || mode !== 2'd2) begin
      fails++;
      $display("FAIL stray_ready: busy=%b valid=%b mode=%0d, want 0 0 2", busy, valid, mode);
    end
  endtask

`ifdef LED_MODE_MASTER_REVERSE_EN
  task automatic test_reverse();
    do_reset();
    resp_reg = 1'b1;
    reverse = 1'b1;
    step();
    reverse = 1'b0;
    tests++;
    if (data !== 2'd3 || valid !== 1'b1) begin
      fails++;
      $display("FAIL reverse_data: data=%0d valid=%b, want 3 1", data, valid);
    end
    cyc(4);
    tests++;
    if (mode !== 2'd3) begin
      fails++;
      $display("FAIL reverse_mode: mode=%0d, want 3", mode);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_wrap();
    test_ticks();
    test_timeout();
    test_err_clr();
    test_reset_mid();
    test_ready_hold();
`ifdef LED_MODE_MASTER_REVERSE_EN
    test_reverse();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
